// File: rtl/pcm_capture_pkg.sv
// pcm_capture_pkg: shared audio capture constants, state encoding and frame sizing
package pcm_capture_pkg;
  localparam int FIFO_DEPTH = 1024;
  localparam int AF_THRESH  = 768;
  localparam int CNT_W      = 11;
  localparam int PTR_W      = 10;
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_PUT_L_LO = 3'd1;
  localparam state_t ST_PUT_L_HI = 3'd2;
  localparam state_t ST_PUT_R_LO = 3'd3;
  localparam state_t ST_PUT_R_HI = 3'd4;
  function automatic logic [2:0] frame_len(input logic stereo, input logic s16);
    return s16 ? (stereo ? 3'd4 : 3'd2) : (stereo ? 3'd2 : 3'd1);
  endfunction
endpackage

// File: rtl/capture_fifo.sv
// capture_fifo: 1024x8 first-word-fall-through byte FIFO with registered count and flags
module capture_fifo
  import pcm_capture_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_wr,
  input  logic [7:0]       i_wdata,
  input  logic             i_rd,
  output logic [7:0]       o_rdata,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_almost_full,
  output logic             o_full
);
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt, w_after_rd;
  logic [7:0]       r_rdata;
  logic             r_empty, r_almost_full, r_full;
  logic             w_rd, w_wr;
  always_comb begin
    w_rd         = i_rd && (r_count != '0);
    w_wr         = i_wr && ((r_count != CNT_W'(FIFO_DEPTH)) || w_rd);
    w_after_rd   = r_count - CNT_W'(w_rd);
    w_count_nxt  = w_after_rd + CNT_W'(w_wr);
    w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_rd);
  end
  always_ff @(posedge clk)
    if (w_wr && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  // Head register tracks the byte at the front after this cycle; a write into an otherwise empty FIFO bypasses the RAM.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_rdata       <= '0;
      r_empty       <= 1'b1;
      r_almost_full <= 1'b0;
      r_full        <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_empty       <= 1'b1;
      r_almost_full <= 1'b0;
      r_full        <= 1'b0;
    end else begin
      r_wr_ptr      <= r_wr_ptr + PTR_W'(w_wr);
      r_rd_ptr      <= w_rd_ptr_nxt;
      r_count       <= w_count_nxt;
      if (w_count_nxt != '0) r_rdata <= (w_after_rd == '0) ? i_wdata : r_mem[w_rd_ptr_nxt];
      r_empty       <= w_count_nxt == '0;
      r_almost_full <= w_count_nxt >= CNT_W'(AF_THRESH);
      r_full        <= w_count_nxt == CNT_W'(FIFO_DEPTH);
    end
  assign o_rdata       = r_rdata;
  assign o_count       = r_count;
  assign o_empty       = r_empty;
  assign o_almost_full = r_almost_full;
  assign o_full        = r_full;
endmodule

// File: rtl/pcm_capture.sv
// pcm_capture: rate-divided stereo/mono PCM sampler packing atomic frames into a byte FIFO
module pcm_capture
  import pcm_capture_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        next_sample,
  input  logic [7:0]  sample_rate,
  input  logic        mode_stereo,
  input  logic        mode_16bit,
  input  logic        enable,
  input  logic [15:0] left_in,
  input  logic [15:0] right_in,
  input  logic        fifo_reset,
  input  logic        fifo_read,
  output logic [7:0]  fifo_rddata,
  output logic        fifo_empty,
  output logic        fifo_almost_full,
  output logic        fifo_full,
  output logic        overflow
);
  logic [7:0]       r_accum, w_accum_nxt;
  logic             r_new_sample;
  state_t           r_state, w_state_nxt;
  logic [15:0]      r_left, r_right;
  logic             r_stereo, r_16bit, r_overflow;
  logic [CNT_W-1:0] w_count, w_free;
  logic             w_fits, w_accept, w_drop, w_wr;
  logic [7:0]       w_wdata;
  always_comb begin
    w_accum_nxt = r_accum + sample_rate;
    w_free      = CNT_W'(FIFO_DEPTH) - w_count;
    w_fits      = w_free >= CNT_W'(frame_len(mode_stereo, mode_16bit));
    w_accept    = r_new_sample && enable && (r_state == ST_IDLE) && w_fits;
    w_drop      = r_new_sample && enable && !((r_state == ST_IDLE) && w_fits);
    w_wr        = r_state != ST_IDLE;
    w_wdata     = r_state == ST_PUT_L_LO ? r_left[7:0]  :
                  r_state == ST_PUT_L_HI ? r_left[15:8] :
                  r_state == ST_PUT_R_LO ? r_right[7:0] : r_right[15:8];
    w_state_nxt = r_state == ST_IDLE     ? (w_accept ? (mode_16bit ? ST_PUT_L_LO : ST_PUT_L_HI) : ST_IDLE) :
                  r_state == ST_PUT_L_LO ? ST_PUT_L_HI :
                  r_state == ST_PUT_L_HI ? (r_stereo ? (r_16bit ? ST_PUT_R_LO : ST_PUT_R_HI) : ST_IDLE) :
                  r_state == ST_PUT_R_LO ? ST_PUT_R_HI : ST_IDLE;
  end
  // A tick whose update toggles the accumulator MSB becomes a sample strobe one cycle later.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_accum      <= '0;
      r_new_sample <= 1'b0;
      r_state      <= ST_IDLE;
      r_left       <= '0;
      r_right      <= '0;
      r_stereo     <= 1'b0;
      r_16bit      <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (next_sample) r_accum <= w_accum_nxt;
      r_new_sample <= next_sample && (w_accum_nxt[7] != r_accum[7]);
      if (fifo_reset) begin
        r_state    <= ST_IDLE;
        r_overflow <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        if (w_drop) r_overflow <= 1'b1;
        if (w_accept) begin
          r_left   <= left_in;
          r_right  <= right_in;
          r_stereo <= mode_stereo;
          r_16bit  <= mode_16bit;
        end
      end
    end
  capture_fifo u_fifo (
    .clk           (clk),
    .rst           (rst),
    .i_flush       (fifo_reset),
    .i_wr          (w_wr),
    .i_wdata       (w_wdata),
    .i_rd          (fifo_read),
    .o_rdata       (fifo_rddata),
    .o_count       (w_count),
    .o_empty       (fifo_empty),
    .o_almost_full (fifo_almost_full),
    .o_full        (fifo_full)
  );
  assign overflow = r_overflow;
endmodule

// File: tb/tb_pcm_capture.sv
// tb_pcm_capture: directed and randomized checks of pcm_capture against a queue-based byte-stream model
module tb_pcm_capture;
  logic        clk = 1'b0, rst = 1'b1;
  logic        next_sample = 1'b0, mode_stereo = 1'b0, mode_16bit = 1'b0, enable = 1'b0;
  logic        fifo_reset = 1'b0, fifo_read = 1'b0;
  logic [7:0]  sample_rate = '0;
  logic [15:0] left_in = '0, right_in = '0;
  logic [7:0]  fifo_rddata;
  logic        fifo_empty, fifo_almost_full, fifo_full, overflow;
  int          checks = 0, failures = 0;
  byte unsigned m_q[$], m_pend[$];
  logic [7:0]  m_acc, m_rd;
  bit          m_ns, m_ovf;

  pcm_capture dut (
    .clk(clk), .rst(rst), .next_sample(next_sample), .sample_rate(sample_rate),
    .mode_stereo(mode_stereo), .mode_16bit(mode_16bit), .enable(enable),
    .left_in(left_in), .right_in(right_in), .fifo_reset(fifo_reset), .fifo_read(fifo_read),
    .fifo_rddata(fifo_rddata), .fifo_empty(fifo_empty), .fifo_almost_full(fifo_almost_full),
    .fifo_full(fifo_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_q.delete();
    m_pend.delete();
    m_acc = '0;
    m_rd  = '0;
    m_ns  = 1'b0;
    m_ovf = 1'b0;
  endfunction

  // Byte-stream reference: a frame is a list of bytes reserved at acceptance and emitted one per cycle.
  function automatic void m_step();
    int           cnt  = m_q.size();
    bit           busy = m_pend.size() != 0;
    byte unsigned fr[$];
    logic [8:0]   sum;
    bit           ns_new;
    if (fifo_reset) begin
      m_q.delete();
      m_pend.delete();
      m_ovf = 1'b0;
    end else begin
      if (fifo_read && cnt > 0) void'(m_q.pop_front());
      if (busy) m_q.push_back(m_pend.pop_front());
      if (m_ns && enable) begin
        if (mode_16bit) fr.push_back(left_in[7:0]);
        fr.push_back(left_in[15:8]);
        if (mode_stereo && mode_16bit) fr.push_back(right_in[7:0]);
        if (mode_stereo) fr.push_back(right_in[15:8]);
        if (busy || (1024 - cnt) < fr.size()) m_ovf = 1'b1;
        else m_pend = fr;
      end
    end
    sum    = {1'b0, m_acc} + {1'b0, sample_rate};
    ns_new = next_sample && (sum[7] != m_acc[7]);
    if (next_sample) m_acc = sum[7:0];
    m_ns = ns_new;
    if (m_q.size() != 0) m_rd = m_q[0];
  endfunction

  task automatic check_all();
    chk("empty", fifo_empty, m_q.size() == 0);
    chk("almost_full", fifo_almost_full, m_q.size() >= 768);
    chk("full", fifo_full, m_q.size() == 1024);
    chk("overflow", overflow, m_ovf);
    chk("rddata", fifo_rddata, m_rd);
  endtask

  task automatic cyc(input bit ns, input bit rd, input bit fr);
    next_sample = ns;
    fifo_read   = rd;
    fifo_reset  = fr;
    @(posedge clk);
    m_step();
    #1;
    check_all();
    next_sample = 1'b0;
    fifo_read   = 1'b0;
    fifo_reset  = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    chk(tag, fifo_rddata, exp);
    cyc(0, 1, 0);
  endtask

  task automatic drain(output int n);
    n = 0;
    while (!fifo_empty && n < 1100) begin
      cyc(0, 1, 0);
      n++;
    end
    if (n >= 1100) chk("drain_timeout", 1, 0);
  endtask

  task automatic set_mode(input bit st, input bit b16);
    mode_stereo = st;
    mode_16bit  = b16;
  endtask

  initial begin
    int n;
    m_reset();
    #17;
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_af", fifo_almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_rddata", fifo_rddata, 8'h00);
    rst = 1'b0;
    cyc(0, 0, 0);

    sample_rate = 8'd128;
    enable      = 1'b1;
    set_mode(1, 1);
    left_in     = 16'h1234;
    right_in    = 16'hABCD;
    cyc(1, 0, 0);
    repeat (5) cyc(0, 0, 0);
    pop_expect("s16_b0", 8'h34);
    pop_expect("s16_b1", 8'h12);
    pop_expect("s16_b2", 8'hCD);
    pop_expect("s16_b3", 8'hAB);
    chk("s16_ovf", overflow, 0);
    chk("s16_empty", fifo_empty, 1);

    set_mode(0, 0);
    left_in  = 16'h80FF;
    right_in = 16'h7F00;
    repeat (3) begin
      cyc(1, 0, 0);
      cyc(0, 0, 0);
    end
    repeat (2) cyc(0, 0, 0);
    pop_expect("m8_b0", 8'h80);
    pop_expect("m8_b1", 8'h80);
    pop_expect("m8_b2", 8'h80);
    chk("m8_empty", fifo_empty, 1);

    sample_rate = 8'd64;
    repeat (8) begin
      cyc(1, 0, 0);
      cyc(0, 0, 0);
    end
    repeat (2) cyc(0, 0, 0);
    drain(n);
    chk("half_rate_bytes", n, 4);

    sample_rate = 8'd128;
    repeat (1023) begin
      cyc(1, 0, 0);
      cyc(0, 0, 0);
    end
    repeat (2) cyc(0, 0, 0);
    chk("fill_af", fifo_almost_full, 1);
    chk("fill_full", fifo_full, 0);
    chk("fill_ovf", overflow, 0);
    set_mode(0, 1);
    cyc(1, 0, 0);
    repeat (4) cyc(0, 0, 0);
    chk("drop_ovf", overflow, 1);
    chk("drop_full", fifo_full, 0);
    drain(n);
    chk("drop_count", n, 1023);

    set_mode(1, 1);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    chk("flush_empty", fifo_empty, 1);
    chk("flush_ovf", overflow, 0);
    repeat (4) cyc(0, 0, 0);
    chk("flush_idle", fifo_empty, 1);

    cyc(0, 1, 0);
    chk("pop_empty", fifo_empty, 1);

    repeat (255) begin
      cyc(1, 0, 0);
      repeat (4) cyc(0, 0, 0);
    end
    chk("fill1020_full", fifo_full, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    repeat (4) cyc(0, 1, 0);
    chk("rw_full", fifo_full, 0);
    cyc(1, 0, 0);
    repeat (5) cyc(0, 0, 0);
    chk("at_full", fifo_full, 1);
    cyc(1, 1, 0);
    repeat (3) cyc(0, 0, 0);
    chk("full_drop_ovf", overflow, 1);
    chk("full_drop_full", fifo_full, 0);
    cyc(0, 0, 1);

    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    #2 rst = 1'b1;
    #1;
    m_reset();
    chk("mrst_empty", fifo_empty, 1);
    chk("mrst_full", fifo_full, 0);
    chk("mrst_af", fifo_almost_full, 0);
    chk("mrst_ovf", overflow, 0);
    chk("mrst_rddata", fifo_rddata, 8'h00);
    @(negedge clk) rst = 1'b0;
    repeat (6) cyc(0, 0, 0);
    chk("post_rst_empty", fifo_empty, 1);

    repeat (3000) begin
      if ($urandom_range(0, 49) == 0) set_mode($urandom_range(0, 1), $urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) begin
        case ($urandom_range(0, 3))
          0: sample_rate = 8'd0;
          1: sample_rate = 8'd64;
          2: sample_rate = 8'd128;
          default: sample_rate = 8'($urandom);
        endcase
      end
      enable   = $urandom_range(0, 9) != 0;
      left_in  = 16'($urandom);
      right_in = 16'($urandom);
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 4) < 2, $urandom_range(0, 149) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
